// File: rtl/led_tick_ctrl.sv
// -----------------------------------------------------------------------------
// led_tick_ctrl
//
// Drives the 7-bit LED counter from a single push-button. Everything runs on
// clk30; the count advances on single-cycle tick enables from a prescaler
// rather than on a derived clock.
//
//   * btn_n is synchronised, debounced, then classified as a short or long
//     press.
//   * A PAUSED / STEP / RUNNING state machine gates the prescaler:
//       PAUSED  : short press -> RUNNING, long press -> STEP
//       STEP    : one cycle, issues one tick, back to PAUSED
//       RUNNING : short press -> PAUSED, long press clears the count
//   * The prescaler period is CLK_FREQ >> rate_sel cycles (1/2/4/8 Hz).
//
// Ports:
//   clk30     in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   btn_n     in   raw push-button, asynchronous, 0 = pressed
//   rate_sel  in   [1:0] tick rate: 00 1 Hz, 01 2 Hz, 10 4 Hz, 11 8 Hz
//   tick      out  one-cycle pulse per count advance
//   count     out  [6:0] LED count
//   running   out  1 while in RUNNING
//   long_evt  out  one-cycle pulse when a press qualifies as long
// -----------------------------------------------------------------------------
module led_tick_ctrl #(
    parameter int unsigned CLK_FREQ          = 30000000,
    parameter int unsigned DEBOUNCE_CYCLES   = 300000,
    parameter int unsigned LONG_PRESS_CYCLES = 30000000
) (
    input  logic       clk30,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic [1:0] rate_sel,
    output logic       tick,
    output logic [6:0] count,
    output logic       running,
    output logic       long_evt
);

    // -------------------------------------------------------------------------
    // Counter widths. The hold counter must be able to hold LONG_PRESS_CYCLES
    // itself because it saturates there.
    // -------------------------------------------------------------------------
    localparam int unsigned PS_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        StPaused  = 2'd0,
        StStep    = 2'd1,
        StRunning = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser. Resets to the released level so a button held
    // through reset is seen as a fresh press afterwards.
    // -------------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce. The counter runs only while the synced level disagrees with
    // the accepted level; any agreement restarts it, so short glitches never
    // get through.
    // -------------------------------------------------------------------------
    logic            db_level_q;
    logic            db_prev_q;
    logic [DB_W-1:0] db_cnt_q;

    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            db_level_q <= 1'b1;
            db_prev_q  <= 1'b1;
            db_cnt_q   <= '0;
        end else begin
            db_prev_q <= db_level_q;
            if (sync2_q != db_level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_level_q <= sync2_q;
                    db_cnt_q   <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    logic pressed;
    logic press_edge;
    logic release_edge;

    assign pressed      = ~db_level_q;
    assign press_edge   = db_prev_q & ~db_level_q;
    assign release_edge = ~db_prev_q & db_level_q;

    // -------------------------------------------------------------------------
    // Press classification. hold_q counts pressed cycles and saturates, so
    // long_evt fires once per press and a release after it is silent.
    // -------------------------------------------------------------------------
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              short_evt_q;
    logic              long_hit;

    always_comb begin
        hold_d = hold_q;
        if (press_edge) begin
            hold_d = '0;
        end else if (pressed && (hold_q < HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Fires only on the step into LONG-1, never while sitting there.
    assign long_hit = pressed && (hold_d == HOLD_LONG) && (press_edge || (hold_q != HOLD_LONG));

    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            long_evt    <= 1'b0;
            short_evt_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            long_evt    <= long_hit;
            short_evt_q <= release_edge && (hold_q < HOLD_LONG);
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler limit. The >= compare in the FSM lets a rate increase that
    // lands below the current prescaler value wrap on the next cycle.
    // -------------------------------------------------------------------------
    logic [PS_W-1:0] ps_limit;
    logic [PS_W-1:0] ps_q;
    logic            ps_wrap;

    always_comb begin
        if ((CLK_FREQ >> rate_sel) > 0) begin
            ps_limit = PS_W'((CLK_FREQ >> rate_sel) - 1);
        end else begin
            ps_limit = '0;
        end
    end

    assign ps_wrap = (ps_q >= ps_limit);

    // -------------------------------------------------------------------------
    // Main state machine with prescaler, tick and count.
    // tick is registered: it is high in the cycle after a prescaler wrap, and
    // for the whole single STEP cycle.
    // -------------------------------------------------------------------------
    state_e state_q;

    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StPaused;
            ps_q    <= '0;
            tick    <= 1'b0;
            count   <= '0;
        end else begin
            tick <= 1'b0;

            case (state_q)
                StPaused: begin
                    ps_q <= '0;
                    if (short_evt_q) begin
                        state_q <= StRunning;
                    end else if (long_evt) begin
                        state_q <= StStep;
                        tick    <= 1'b1;
                    end
                end

                StStep: begin
                    ps_q    <= '0;
                    state_q <= StPaused;
                end

                StRunning: begin
                    if (ps_wrap) begin
                        ps_q <= '0;
                        tick <= 1'b1;
                    end else begin
                        ps_q <= ps_q + 1'b1;
                    end
                    // A wrap coinciding with the pause still delivers its tick.
                    if (short_evt_q) begin
                        state_q <= StPaused;
                        ps_q    <= '0;
                    end
                end

                default: begin
                    state_q <= StPaused;
                    ps_q    <= '0;
                end
            endcase

            // Clear wins over a tick landing in the same cycle.
            if ((state_q == StRunning) && long_evt) begin
                count <= '0;
            end else if (tick) begin
                count <= count + 1'b1;
            end
        end
    end

    assign running = (state_q == StRunning);

endmodule

// File: tb/tb_led_tick_ctrl.sv
module tb_led_tick_ctrl;

    localparam int unsigned CF = 16;
    localparam int unsigned DB = 4;
    localparam int unsigned LP = 20;

    logic       clk30 = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_n = 1'b1;
    logic [1:0] rate_sel = 2'b00;
    logic       tick;
    logic [6:0] count;
    logic       running;
    logic       long_evt;

    int checks = 0;
    int errors = 0;

    led_tick_ctrl #(
        .CLK_FREQ          (CF),
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .clk30    (clk30),
        .rst_n    (rst_n),
        .btn_n    (btn_n),
        .rate_sel (rate_sel),
        .tick     (tick),
        .count    (count),
        .running  (running),
        .long_evt (long_evt)
    );

    always #5 clk30 = ~clk30;

    // Hold the button low for n cycles; called and returns on a falling edge.
    task automatic press(input int n);
        btn_n = 1'b0;
        repeat (n) @(negedge clk30);
        btn_n = 1'b1;
    endtask

    // Cycles until running reaches lvl, bounded.
    task automatic wait_running(input logic lvl, output int cyc);
        cyc = 0;
        while (running !== lvl && cyc < 60) begin
            @(negedge clk30);
            cyc++;
        end
    endtask

    task automatic test_reset();
        int ticks;
        int runs;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk30);
        checks++;
        if (running !== 1'b0 || tick !== 1'b0 || long_evt !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: running=%b tick=%b long=%b, expected 0 0 0",
                     running, tick, long_evt);
        end
        rst_n = 1'b1;
        ticks = 0;
        runs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk30);
            if (tick === 1'b1) ticks++;
            if (running === 1'b1) runs++;
        end
        checks++;
        if (ticks != 0) begin
            errors++;
            $display("FAIL idle_ticks: got %0d ticks, expected 0", ticks);
        end
        checks++;
        if (runs != 0) begin
            errors++;
            $display("FAIL idle_running: got %0d running cycles, expected 0", runs);
        end
        checks++;
        if (count !== 7'd0) begin
            errors++;
            $display("FAIL idle_count: got %0d, expected 0", count);
        end
    endtask

    task automatic test_glitch();
        int ev;
        press(3);
        ev = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk30);
            if (running === 1'b1 || tick === 1'b1 || long_evt === 1'b1) ev++;
        end
        checks++;
        if (ev != 0) begin
            errors++;
            $display("FAIL glitch_events: got %0d active cycles, expected 0", ev);
        end
        checks++;
        if (count !== 7'd0) begin
            errors++;
            $display("FAIL glitch_count: got %0d, expected 0", count);
        end
    endtask

    task automatic test_short_start();
        int cyc;
        press(10);
        wait_running(1'b1, cyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL start_latency: got %0d cycles, expected 8", cyc);
        end
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            do begin
                @(negedge clk30);
                cyc++;
            end while (tick !== 1'b1 && cyc < 40);
            checks++;
            if (cyc != 16) begin
                errors++;
                $display("FAIL tick_period_%0d: got %0d cycles, expected 16", i, cyc);
            end
            checks++;
            if (count !== 7'(i)) begin
                errors++;
                $display("FAIL count_at_tick_%0d: got %0d, expected %0d", i, count, i);
            end
        end
    endtask

    task automatic test_rate_change();
        logic [5:0] pat;
        // Prescaler is 0 at the tick sample; 10 cycles later it reads 10.
        repeat (10) @(negedge clk30);
        rate_sel = 2'b11;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk30);
            pat[5-i] = tick;
        end
        checks++;
        if (pat !== 6'b101010) begin
            errors++;
            $display("FAIL rate_change_ticks: got %b, expected 101010", pat);
        end
        checks++;
        if (count !== 7'd6) begin
            errors++;
            $display("FAIL rate_change_count: got %0d, expected 6", count);
        end
    endtask

    task automatic test_count_wrap();
        int cyc;
        cyc = 0;
        while (count !== 7'd127 && cyc < 400) begin
            @(negedge clk30);
            cyc++;
        end
        checks++;
        if (count !== 7'd127) begin
            errors++;
            $display("FAIL reach_127: got %0d after %0d cycles, expected 127", count, cyc);
        end
        cyc = 0;
        while (tick !== 1'b1 && cyc < 4) begin
            @(negedge clk30);
            cyc++;
        end
        @(negedge clk30);
        checks++;
        if (count !== 7'd0) begin
            errors++;
            $display("FAIL wrap_to_0: got %0d, expected 0", count);
        end
    endtask

    task automatic test_clear_coincident();
        int cyc;
        int longs;
        int drops;
        cyc = 0;
        while (tick !== 1'b1 && cyc < 4) begin
            @(negedge clk30);
            cyc++;
        end
        // Ticks every 2 cycles, long_evt 26 cycles after press: they coincide.
        btn_n = 1'b0;
        longs = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk30);
            if (long_evt === 1'b1) longs++;
            if (k == 26) begin
                checks++;
                if (long_evt !== 1'b1 || tick !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_align: long=%b tick=%b, expected 1 1", long_evt, tick);
                end
            end
            if (k == 27) begin
                checks++;
                if (count !== 7'd0) begin
                    errors++;
                    $display("FAIL clear_priority: got count %0d, expected 0", count);
                end
            end
        end
        btn_n = 1'b1;
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk30);
            if (running !== 1'b1) drops++;
        end
        checks++;
        if (longs != 1) begin
            errors++;
            $display("FAIL run_long_pulses: got %0d, expected 1", longs);
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL run_stays_running: got %0d idle cycles, expected 0", drops);
        end
    endtask

    task automatic test_long_from_paused();
        int cyc;
        int first;
        int longs;
        int ticks;
        int runs;
        logic [6:0] base;
        press(10);
        wait_running(1'b0, cyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL pause_latency: got %0d cycles, expected 8", cyc);
        end
        repeat (4) @(negedge clk30);
        base = count;
        btn_n = 1'b0;
        first = -1;
        longs = 0;
        ticks = 0;
        runs = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk30);
            if (long_evt === 1'b1) begin
                longs++;
                if (first < 0) first = k;
            end
            if (tick === 1'b1) ticks++;
            if (running === 1'b1) runs++;
            if (k == 30) btn_n = 1'b1;
        end
        checks++;
        if (first != 26) begin
            errors++;
            $display("FAIL long_time: got cycle %0d, expected 26", first);
        end
        checks++;
        if (longs != 1) begin
            errors++;
            $display("FAIL long_pulses: got %0d, expected 1", longs);
        end
        checks++;
        if (ticks != 1) begin
            errors++;
            $display("FAIL step_ticks: got %0d, expected 1", ticks);
        end
        checks++;
        if (runs != 0) begin
            errors++;
            $display("FAIL step_running: got %0d running cycles, expected 0", runs);
        end
        checks++;
        if (count !== 7'(base + 7'd1)) begin
            errors++;
            $display("FAIL step_count: got %0d, expected %0d", count, 7'(base + 7'd1));
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        int first;
        press(10);
        wait_running(1'b1, cyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL restart_latency: got %0d cycles, expected 8", cyc);
        end
        btn_n = 1'b0;
        repeat (10) @(negedge clk30);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (running !== 1'b0 || count !== 7'd0 || tick !== 1'b0 || long_evt !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: running=%b count=%0d tick=%b long=%b, expected all 0",
                     running, count, tick, long_evt);
        end
        @(negedge clk30);
        rst_n = 1'b1;
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk30);
            if (long_evt === 1'b1 && first < 0) first = k;
        end
        checks++;
        if (first != 26) begin
            errors++;
            $display("FAIL redebounce_long: got cycle %0d, expected 26", first);
        end
        btn_n = 1'b1;
        repeat (20) @(negedge clk30);
        checks++;
        if (count !== 7'd1 || running !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_step: count=%0d running=%b, expected 1 0", count, running);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_short_start();
        test_rate_change();
        test_count_wrap();
        test_clear_coincident();
        test_long_from_paused();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_tick_ctrl.md
Name: led_tick_ctrl

Overview:
- Sequences the 7-bit LED counter on the 30 MHz board from one user push-button.
- Debounces the button and classifies each press as short or long.
- A RUN/PAUSE/STEP state machine gates a rate-selectable prescaler that issues single-cycle tick enables.
- Owns the LED count, driven by those ticks. Replaces derived-clock counting; everything runs on clk30.

Parameters:
- CLK_FREQ, 30000000, clk30 cycles per 1 Hz tick period.
- DEBOUNCE_CYCLES, 300000, stable cycles required to accept a button level change (10 ms).
- LONG_PRESS_CYCLES, 30000000, held cycles that qualify a press as long (1 s).

Ports:
- clk30  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_n  input  1  raw push-button, asynchronous, 0 = pressed.
- rate_sel  input  2  tick rate: 00 = 1 Hz, 01 = 2 Hz, 10 = 4 Hz, 11 = 8 Hz.
- tick  output  1  one-cycle pulse per count advance.
- count  output  7  LED count value.
- running  output  1  1 while in RUNNING.
- long_evt  output  1  one-cycle pulse when a long press qualifies (debug/visibility).

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - State = PAUSED.
  - tick = 0, count = 0, running = 0, long_evt = 0.
  - Prescaler, debounce and hold counters = 0.
  - Synchronizer and debounced level = 1 (released).
  - Reset mid-press or mid-period discards all progress. After release, the button must go through full debounce again.
- Synchronizer:
  - btn_n passes through 2 flops. Debounce logic sees only the synced level.
- Debounce:
  - When synced != debounced, the counter increments. When synced == debounced, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level updates and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the debounced level.
- Press classification:
  - The hold counter clears on a debounced press edge, increments while pressed, and saturates at LONG_PRESS_CYCLES.
  - long_evt pulses exactly once, in the cycle the counter reaches LONG_PRESS_CYCLES-1, while the button is still held.
  - Release with hold < LONG_PRESS_CYCLES-1 produces short_evt (internal, one cycle) on the debounced release edge.
  - Release after long_evt produces no event.
  - short_evt and long_evt are mutually exclusive per press.
- FSM:
  - PAUSED: short_evt -> RUNNING. long_evt -> STEP. Otherwise hold.
  - STEP: lasts exactly one cycle, asserts tick, then -> PAUSED.
  - RUNNING: short_evt -> PAUSED. long_evt -> assert clear (count <= 0) and stay RUNNING. The prescaler continues.
  - running = 1 exactly while state == RUNNING (registered state decode).
- Prescaler:
  - Active only in RUNNING. Held at 0 in PAUSED/STEP, so entering RUNNING always starts a full period.
  - limit = (CLK_FREQ >> rate_sel) - 1.
  - When prescaler >= limit: prescaler <= 0 and tick pulses the following cycle (registered). Otherwise prescaler increments.
  - The >= compare means a rate_sel increase mid-period wraps on the next cycle. It never runs past the limit.
  - First tick occurs CLK_FREQ>>rate_sel cycles after entering RUNNING (±1 for the registered tick, fixed by RTL and held constant).
- Leaving RUNNING on the same cycle as a prescaler wrap:
  - The wrap's tick still issues.
  - The prescaler clears.
- Count:
  - Increments by 1 on each cycle with tick = 1.
  - 7-bit wrap: 127 -> 0.
  - Clear has priority over tick in the same cycle: result 0.
  - count never changes without tick or clear.
- Width rules:
  - Prescaler, debounce and hold counters are sized by $clog2 of their parameter. No truncation at default parameters.

Test Plan (CLK_FREQ = 16, DEBOUNCE_CYCLES = 4, LONG_PRESS_CYCLES = 20 unless noted):
- Reset, btn_n = 1 for 100 cycles -> tick never pulses, count = 0, running = 0.
- 3-cycle low glitch on btn_n -> no state change. Press held 10 cycles -> running = 1 about 2 + 4 cycles after release. rate_sel = 00 -> tick every 16 cycles, count 0,1,2…
- In RUNNING: rate_sel 00 -> 11 when prescaler = 10 -> tick next cycle. Subsequent ticks every 2 cycles.
- From PAUSED, hold 30 cycles -> long_evt one pulse at hold = 19, one tick, count +1, running stays 0. No event on release.
- In RUNNING with count = 127: next tick -> count = 0. Long press -> count = 0 and running stays 1. Clear coincident with tick -> count = 0.
- Assert rst_n low mid-press and mid-period -> all outputs 0 immediately (asynchronous). After rst_n release, a still-held button must re-debounce before any event.
